// File: rtl/pwm_timebase_pkg.sv
// Shared definitions for the PWM timebase controller: register map, CTRL bit
// positions, FSM encoding and address decode helper.
package pwm_timebase_pkg;

    localparam int CFG_DW = 16;

    localparam logic [2:0] ADDR_PERIOD = 3'd0;
    localparam logic [2:0] ADDR_CMP1   = 3'd1;
    localparam logic [2:0] ADDR_CMP2   = 3'd2;
    localparam logic [2:0] ADDR_FUNC   = 3'd3;
    localparam logic [2:0] ADDR_PSC    = 3'd4;
    localparam logic [2:0] ADDR_CTRL   = 3'd5;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_ONESHOT  = 1;
    localparam int CTRL_FORCE    = 2;
    localparam int CTRL_IRQ_MASK = 3;
    localparam int CTRL_IRQ_CLR  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tb_state_e;

    // Addresses 0..4 land in the double-buffered shadow bank.
    function automatic logic is_shadow_addr(input logic [2:0] addr);
        return (addr <= ADDR_PSC);
    endfunction

endpackage

// File: rtl/pwm_timebase_ctrl_if.sv
// Host configuration write bus into the PWM timebase controller.
interface pwm_timebase_ctrl_if;
    import pwm_timebase_pkg::*;

    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic [CFG_DW-1:0] cfg_wdata;

    modport master (output cfg_we, output cfg_addr, output cfg_wdata);
    modport slave  (input  cfg_we, input  cfg_addr, input  cfg_wdata);

endinterface

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..psc_i while running and flags the terminal count as a tick.
module pwm_prescaler
    import pwm_timebase_pkg::*;
#(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PSC_W-1:0] psc_i,
    input  logic             clear_i,
    input  logic             run_i,
    output logic             tick_o
);

    logic [PSC_W-1:0] cnt_q;
    logic [PSC_W-1:0] cnt_d;

    assign tick_o = run_i && (cnt_q == psc_i);

    // Next prescaler count: restart on clear, stop or tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !run_i || tick_o) begin
            cnt_d = {PSC_W{1'b0}};
        end else begin
            cnt_d = cnt_q + PSC_W'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {PSC_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_timebase_ctrl.sv
// PWM timebase and glitch-free register update controller. Optional interrupt
// output enabled by defining PWM_TIMEBASE_IRQ_EN.
module pwm_timebase_ctrl
    import pwm_timebase_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PSC_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_timebase_ctrl_if.slave  cfg,
    output logic                pwm_en_o,
    output logic [CNT_W-1:0]    period_o,
    output logic [7:0]          functions_o,
    output logic [CNT_W-1:0]    compare1_o,
    output logic [CNT_W-1:0]    compare2_o,
    output logic [CNT_W-1:0]    count_val_o,
    output logic                wrap_pulse_o,
`ifdef PWM_TIMEBASE_IRQ_EN
    output logic                irq_o,
`endif
    output logic                upd_pending_o
);

    tb_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] sh_period_q, sh_period_d, act_period_q, act_period_d;
    logic [CNT_W-1:0] sh_cmp1_q, sh_cmp1_d, act_cmp1_q, act_cmp1_d;
    logic [CNT_W-1:0] sh_cmp2_q, sh_cmp2_d, act_cmp2_q, act_cmp2_d;
    logic [7:0]       sh_func_q, sh_func_d, act_func_q, act_func_d;
    logic [PSC_W-1:0] sh_psc_q, sh_psc_d, act_psc_q, act_psc_d;
    logic             pending_q, pending_d;
    logic             oneshot_q, oneshot_d;
    logic             sh_wr_s, ctrl_wr_s, tick_s, psc_clear_s, load_s, wrap_evt_s;
`ifdef PWM_TIMEBASE_IRQ_EN
    logic             irq_q, irq_d, irq_mask_q, irq_mask_d;
`endif

    assign sh_wr_s   = cfg.cfg_we && is_shadow_addr(cfg.cfg_addr);
    assign ctrl_wr_s = cfg.cfg_we && (cfg.cfg_addr == ADDR_CTRL);

    pwm_prescaler #(.PSC_W(PSC_W)) u_psc (
        .clk     (clk),
        .rst_n   (rst_n),
        .psc_i   (act_psc_q),
        .clear_i (psc_clear_s),
        .run_i   (state_q == ST_RUN),
        .tick_o  (tick_s)
    );

    // Shadow writes, FSM, counter and active-bank load decision.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pending_d   = pending_q;
        sh_period_d = sh_period_q;
        sh_cmp1_d   = sh_cmp1_q;
        sh_cmp2_d   = sh_cmp2_q;
        sh_func_d   = sh_func_q;
        sh_psc_d    = sh_psc_q;
        psc_clear_s = 1'b0;
        load_s      = 1'b0;
        wrap_evt_s  = 1'b0;

        if (cfg.cfg_we) begin
            case (cfg.cfg_addr)
                ADDR_PERIOD: sh_period_d = cfg.cfg_wdata[CNT_W-1:0];
                ADDR_CMP1:   sh_cmp1_d   = cfg.cfg_wdata[CNT_W-1:0];
                ADDR_CMP2:   sh_cmp2_d   = cfg.cfg_wdata[CNT_W-1:0];
                ADDR_FUNC:   sh_func_d   = cfg.cfg_wdata[7:0];
                ADDR_PSC:    sh_psc_d    = cfg.cfg_wdata[PSC_W-1:0];
                default:     sh_period_d = sh_period_q;
            endcase
        end else begin
            sh_period_d = sh_period_q;
        end

        if (ctrl_wr_s) begin
            oneshot_d = cfg.cfg_wdata[CTRL_ONESHOT];
        end else begin
            oneshot_d = oneshot_q;
        end

        case (state_q)
            ST_IDLE: begin
                load_s      = 1'b1;
                pending_d   = 1'b0;
                count_d     = {CNT_W{1'b0}};
                psc_clear_s = 1'b1;
                if (ctrl_wr_s && cfg.cfg_wdata[CTRL_EN]) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ctrl_wr_s && !cfg.cfg_wdata[CTRL_EN]) begin
                    state_d     = ST_IDLE;
                    count_d     = {CNT_W{1'b0}};
                    load_s      = 1'b1;
                    pending_d   = 1'b0;
                    psc_clear_s = 1'b1;
                end else if (ctrl_wr_s && cfg.cfg_wdata[CTRL_FORCE]) begin
                    count_d     = {CNT_W{1'b0}};
                    load_s      = 1'b1;
                    pending_d   = 1'b0;
                    psc_clear_s = 1'b1;
                end else if (tick_s && (count_q == act_period_q)) begin
                    // A write landing on the wrap edge is held for the next wrap.
                    wrap_evt_s = 1'b1;
                    count_d    = {CNT_W{1'b0}};
                    load_s     = pending_q;
                    pending_d  = sh_wr_s;
                    if (oneshot_q) begin
                        state_d   = ST_IDLE;
                        load_s    = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (tick_s) begin
                    count_d   = count_q + CNT_W'(1);
                    pending_d = pending_q | sh_wr_s;
                end else begin
                    pending_d = pending_q | sh_wr_s;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                count_d     = {CNT_W{1'b0}};
                pending_d   = 1'b0;
                psc_clear_s = 1'b1;
            end
        endcase

        if (load_s) begin
            act_period_d = sh_period_q;
            act_cmp1_d   = sh_cmp1_q;
            act_cmp2_d   = sh_cmp2_q;
            act_func_d   = sh_func_q;
            act_psc_d    = sh_psc_q;
        end else begin
            act_period_d = act_period_q;
            act_cmp1_d   = act_cmp1_q;
            act_cmp2_d   = act_cmp2_q;
            act_func_d   = act_func_q;
            act_psc_d    = act_psc_q;
        end
    end

`ifdef PWM_TIMEBASE_IRQ_EN
    // Sticky wrap interrupt; a set on the same clock as a clear takes priority.
    always_comb begin
        irq_d      = irq_q;
        irq_mask_d = irq_mask_q;
        if (ctrl_wr_s) begin
            irq_mask_d = cfg.cfg_wdata[CTRL_IRQ_MASK];
        end else begin
            irq_mask_d = irq_mask_q;
        end
        if (wrap_evt_s && irq_mask_q) begin
            irq_d = 1'b1;
        end else if (ctrl_wr_s && cfg.cfg_wdata[CTRL_IRQ_CLR]) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Interrupt state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q      <= 1'b0;
            irq_mask_q <= 1'b0;
        end else begin
            irq_q      <= irq_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    assign irq_o = irq_q;
`endif

    // Timebase state, shadow bank and active bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= {CNT_W{1'b0}};
            pending_q    <= 1'b0;
            oneshot_q    <= 1'b0;
            sh_period_q  <= {CNT_W{1'b0}};
            sh_cmp1_q    <= {CNT_W{1'b0}};
            sh_cmp2_q    <= {CNT_W{1'b0}};
            sh_func_q    <= 8'd0;
            sh_psc_q     <= {PSC_W{1'b0}};
            act_period_q <= {CNT_W{1'b0}};
            act_cmp1_q   <= {CNT_W{1'b0}};
            act_cmp2_q   <= {CNT_W{1'b0}};
            act_func_q   <= 8'd0;
            act_psc_q    <= {PSC_W{1'b0}};
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            oneshot_q    <= oneshot_d;
            sh_period_q  <= sh_period_d;
            sh_cmp1_q    <= sh_cmp1_d;
            sh_cmp2_q    <= sh_cmp2_d;
            sh_func_q    <= sh_func_d;
            sh_psc_q     <= sh_psc_d;
            act_period_q <= act_period_d;
            act_cmp1_q   <= act_cmp1_d;
            act_cmp2_q   <= act_cmp2_d;
            act_func_q   <= act_func_d;
            act_psc_q    <= act_psc_d;
        end
    end

    assign pwm_en_o      = (state_q == ST_RUN);
    assign period_o      = act_period_q;
    assign functions_o   = act_func_q;
    assign compare1_o    = act_cmp1_q;
    assign compare2_o    = act_cmp2_q;
    assign count_val_o   = count_q;
    assign upd_pending_o = pending_q;
    // Decoded from registered state only, so no input-to-output path.
    assign wrap_pulse_o  = tick_s && (count_q == act_period_q);

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// Self-checking bench for pwm_timebase_ctrl: directed scenarios plus a randomized
// run against a clocks-since-wrap arithmetic reference model.
module tb_pwm_timebase_ctrl;
    import pwm_timebase_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        pwm_en;
    logic [15:0] period, compare1, compare2, count_val;
    logic [7:0]  functions;
    logic        wrap_pulse, upd_pending;
`ifdef PWM_TIMEBASE_IRQ_EN
    logic        irq;
`endif
    int checks = 0;
    int errors = 0;

    pwm_timebase_ctrl_if cfg();

    pwm_timebase_ctrl #(.CNT_W(16), .PSC_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg           (cfg),
        .pwm_en_o      (pwm_en),
        .period_o      (period),
        .functions_o   (functions),
        .compare1_o    (compare1),
        .compare2_o    (compare2),
        .count_val_o   (count_val),
        .wrap_pulse_o  (wrap_pulse),
`ifdef PWM_TIMEBASE_IRQ_EN
        .irq_o         (irq),
`endif
        .upd_pending_o (upd_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: t counts clocks since run start / last wrap / force load.
    bit m_run, m_pend, m_oneshot;
    int m_t;
    int m_sh[5];
    int m_act[5];

    function automatic int m_count();
        return m_run ? (m_t / (m_act[4] + 1)) : 0;
    endfunction

    function automatic bit m_wrap();
        return m_run && (m_t == (m_act[0] + 1) * (m_act[4] + 1) - 1);
    endfunction

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_oneshot = 0; m_t = 0;
        for (int j = 0; j < 5; j++) begin m_sh[j] = 0; m_act[j] = 0; end
    endtask

    task automatic model_copy();
        for (int j = 0; j < 5; j++) m_act[j] = m_sh[j];
    endtask

    task automatic model_clock(input bit we, input int a, input int d);
        bit sh_wr, ctrl, wrap_now;
        sh_wr = we && (a <= 4);
        ctrl = we && (a == 5);
        wrap_now = m_wrap();
        if (!m_run) begin
            model_copy(); m_pend = 0; m_t = 0;
            if (ctrl && d[0]) m_run = 1;
        end else if (ctrl && !d[0]) begin
            m_run = 0; m_t = 0; model_copy(); m_pend = 0;
        end else if (ctrl && d[2]) begin
            model_copy(); m_pend = 0; m_t = 0;
        end else if (wrap_now) begin
            if (m_pend) model_copy();
            m_pend = sh_wr; m_t = 0;
            if (m_oneshot) begin m_run = 0; model_copy(); m_pend = 0; end
        end else begin
            m_t++;
            if (sh_wr) m_pend = 1;
        end
        if (ctrl) m_oneshot = d[1];
        if (sh_wr) m_sh[a] = (a >= 3) ? (d & 255) : (d & 65535);
    endtask

    task automatic drive(input logic we, input logic [2:0] a, input logic [15:0] d);
        cfg.cfg_we = we; cfg.cfg_addr = a; cfg.cfg_wdata = d;
        @(posedge clk); #1;
        cfg.cfg_we = 1'b0;
    endtask

    task automatic apply_reset();
        cfg.cfg_we = 1'b0; cfg.cfg_addr = 3'd0; cfg.cfg_wdata = 16'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (pwm_en !== 1'b0) begin errors++; $display("FAIL reset_pwm_en got %0b exp 0", pwm_en); end
        checks++; if (count_val !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_val); end
        checks++; if (period !== 16'd0) begin errors++; $display("FAIL reset_period got %0d exp 0", period); end
        checks++; if (compare1 !== 16'd0 || compare2 !== 16'd0) begin errors++; $display("FAIL reset_cmp got %0d/%0d exp 0/0", compare1, compare2); end
        checks++; if (functions !== 8'd0) begin errors++; $display("FAIL reset_func got %0d exp 0", functions); end
        checks++; if (wrap_pulse !== 1'b0 || upd_pending !== 1'b0) begin errors++; $display("FAIL reset_flags got %0b%0b exp 00", wrap_pulse, upd_pending); end
    endtask

    task automatic test_basic_count();
        apply_reset();
        drive(1'b1, ADDR_PERIOD, 16'd4);
        drive(1'b1, ADDR_PSC, 16'd0);
        drive(1'b1, ADDR_CTRL, 16'd1);
        for (int i = 0; i < 10; i++) begin
            checks++; if (count_val !== 16'(i % 5)) begin errors++; $display("FAIL t1_count i=%0d got %0d exp %0d", i, count_val, i % 5); end
            checks++; if (wrap_pulse !== ((i % 5) == 4)) begin errors++; $display("FAIL t1_wrap i=%0d got %0b exp %0b", i, wrap_pulse, (i % 5) == 4); end
            checks++; if (pwm_en !== 1'b1) begin errors++; $display("FAIL t1_pwm_en i=%0d got %0b exp 1", i, pwm_en); end
            drive(1'b0, 3'd0, 16'd0);
        end
    endtask

    task automatic test_prescaler();
        apply_reset();
        drive(1'b1, ADDR_PSC, 16'd2);
        drive(1'b1, ADDR_PERIOD, 16'd1);
        drive(1'b1, ADDR_CTRL, 16'd1);
        for (int i = 0; i < 12; i++) begin
            checks++; if (count_val !== 16'((i / 3) % 2)) begin errors++; $display("FAIL t2_count i=%0d got %0d exp %0d", i, count_val, (i / 3) % 2); end
            checks++; if (wrap_pulse !== ((i % 6) == 5)) begin errors++; $display("FAIL t2_wrap i=%0d got %0b exp %0b", i, wrap_pulse, (i % 6) == 5); end
            drive(1'b0, 3'd0, 16'd0);
        end
    endtask

    task automatic test_shadow_update();
        apply_reset();
        drive(1'b1, ADDR_PERIOD, 16'd4);
        drive(1'b1, ADDR_CMP1, 16'd2);
        drive(1'b1, ADDR_CTRL, 16'd1);
        drive(1'b0, 3'd0, 16'd0);
        checks++; if (count_val !== 16'd1) begin errors++; $display("FAIL t3_start got %0d exp 1", count_val); end
        drive(1'b1, ADDR_CMP1, 16'd3);
        for (int i = 2; i <= 4; i++) begin
            checks++; if (compare1 !== 16'd2) begin errors++; $display("FAIL t3_hold cnt=%0d got %0d exp 2", i, compare1); end
            checks++; if (upd_pending !== 1'b1) begin errors++; $display("FAIL t3_pending cnt=%0d got %0b exp 1", i, upd_pending); end
            drive(1'b0, 3'd0, 16'd0);
        end
        checks++; if (count_val !== 16'd0 || compare1 !== 16'd3) begin errors++; $display("FAIL t3_load got cnt %0d cmp1 %0d exp 0/3", count_val, compare1); end
        checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL t3_pending_clr got %0b exp 0", upd_pending); end
    endtask

    task automatic test_write_at_wrap();
        apply_reset();
        drive(1'b1, ADDR_PERIOD, 16'd4);
        drive(1'b1, ADDR_CMP1, 16'd2);
        drive(1'b1, ADDR_CTRL, 16'd1);
        repeat (4) drive(1'b0, 3'd0, 16'd0);
        checks++; if (wrap_pulse !== 1'b1) begin errors++; $display("FAIL t4_wrap got %0b exp 1", wrap_pulse); end
        drive(1'b1, ADDR_CMP1, 16'd3);
        for (int i = 0; i < 5; i++) begin
            checks++; if (compare1 !== 16'd2 || upd_pending !== 1'b1) begin errors++; $display("FAIL t4_held cnt=%0d got cmp1 %0d pend %0b exp 2/1", i, compare1, upd_pending); end
            drive(1'b0, 3'd0, 16'd0);
        end
        checks++; if (compare1 !== 16'd3 || upd_pending !== 1'b0) begin errors++; $display("FAIL t4_load got cmp1 %0d pend %0b exp 3/0", compare1, upd_pending); end
    endtask

    task automatic test_oneshot();
        apply_reset();
        drive(1'b1, ADDR_PERIOD, 16'd2);
        drive(1'b1, ADDR_CTRL, 16'd3);
        for (int i = 0; i < 6; i++) begin
            checks++; if (pwm_en !== (i < 3)) begin errors++; $display("FAIL t5_pwm_en i=%0d got %0b exp %0b", i, pwm_en, i < 3); end
            checks++; if (count_val !== ((i < 3) ? 16'(i) : 16'd0)) begin errors++; $display("FAIL t5_count i=%0d got %0d", i, count_val); end
            drive(1'b0, 3'd0, 16'd0);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(1'b1, ADDR_PERIOD, 16'd5);
        drive(1'b1, ADDR_CTRL, 16'd1);
        repeat (3) drive(1'b0, 3'd0, 16'd0);
        checks++; if (count_val !== 16'd3) begin errors++; $display("FAIL t6_pre got %0d exp 3", count_val); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pwm_en !== 1'b0 || count_val !== 16'd0 || period !== 16'd0) begin errors++; $display("FAIL t6_async got en %0b cnt %0d per %0d exp 0", pwm_en, count_val, period); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) drive(1'b0, 3'd0, 16'd0);
        checks++; if (pwm_en !== 1'b0 || count_val !== 16'd0) begin errors++; $display("FAIL t6_idle got en %0b cnt %0d exp 0/0", pwm_en, count_val); end
        drive(1'b1, ADDR_CTRL, 16'd1);
        checks++; if (pwm_en !== 1'b1) begin errors++; $display("FAIL t6_restart got %0b exp 1", pwm_en); end
    endtask

`ifdef PWM_TIMEBASE_IRQ_EN
    task automatic test_irq();
        apply_reset();
        drive(1'b1, ADDR_PERIOD, 16'd3);
        drive(1'b1, ADDR_CTRL, 16'd9);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %0b exp 0", irq); end
        repeat (4) drive(1'b0, 3'd0, 16'd0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %0b exp 1", irq); end
        drive(1'b1, ADDR_CTRL, 16'd25);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %0b exp 0", irq); end
    endtask
`endif

    task automatic test_random();
        int r, a, d;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            checks++; if (pwm_en !== m_run) begin errors++; $display("FAIL rnd_en n=%0d got %0b exp %0b", n, pwm_en, m_run); end
            checks++; if (count_val !== 16'(m_count())) begin errors++; $display("FAIL rnd_count n=%0d got %0d exp %0d", n, count_val, m_count()); end
            checks++; if (wrap_pulse !== m_wrap()) begin errors++; $display("FAIL rnd_wrap n=%0d got %0b exp %0b", n, wrap_pulse, m_wrap()); end
            checks++; if (upd_pending !== m_pend) begin errors++; $display("FAIL rnd_pend n=%0d got %0b exp %0b", n, upd_pending, m_pend); end
            checks++; if (period !== 16'(m_act[0]) || compare1 !== 16'(m_act[1]) || compare2 !== 16'(m_act[2]) || functions !== 8'(m_act[3])) begin
                errors++; $display("FAIL rnd_active n=%0d got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", n, period, compare1, compare2, functions, m_act[0], m_act[1], m_act[2], m_act[3]);
            end
            r = $urandom_range(0, 11);
            if (r < 4) begin
                a = 0; d = 0;
                drive(1'b0, 3'd0, 16'd0);
                model_clock(1'b0, a, d);
            end else begin
                if (r == 11) begin
                    a = 5;
                    d = (($urandom_range(0, 4) != 0) ? 1 : 0) | (($urandom_range(0, 5) == 0) ? 2 : 0) | (($urandom_range(0, 3) == 0) ? 4 : 0);
                end else if (r == 10) begin
                    a = $urandom_range(6, 7); d = $urandom_range(0, 65535);
                end else begin
                    a = $urandom_range(0, 4);
                    case (a)
                        0:       d = $urandom_range(0, 5);
                        4:       d = ($urandom_range(0, 255) << 8) | $urandom_range(0, 3);
                        default: d = $urandom_range(0, 65535);
                    endcase
                end
                drive(1'b1, 3'(a), 16'(d));
                model_clock(1'b1, a, d);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cfg.cfg_we = 1'b0; cfg.cfg_addr = 3'd0; cfg.cfg_wdata = 16'd0;
        test_reset();
        test_basic_count();
        test_prescaler();
        test_shadow_update();
        test_write_at_wrap();
        test_oneshot();
        test_async_reset();
`ifdef PWM_TIMEBASE_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
